// File: rtl/prbs_line_pkg.sv
// prbs_line_pkg: shared line-code encodings, stock primitive polynomials and
// the rate divider table helper for the PRBS line transmitter family.
package prbs_line_pkg;

  // Line code selection, as driven on the mode input.
  localparam logic [1:0] MODE_NRZ  = 2'd0;
  localparam logic [1:0] MODE_MAN  = 2'd1;
  localparam logic [1:0] MODE_DMAN = 2'd2;
  localparam logic [1:0] MODE_NRZI = 2'd3;

  // Primitive feedback polynomials, bit W included (33 bits so W=32 fits).
  localparam logic [32:0] MASK_W7  = 33'h0_0000_0089;  // x^7+x^3+1
  localparam logic [32:0] MASK_W8  = 33'h0_0000_011d;  // x^8+x^4+x^3+x^2+1
  localparam logic [32:0] MASK_W12 = 33'h0_0000_1053;  // x^12+x^6+x^4+x+1
  localparam logic [32:0] MASK_W15 = 33'h0_0000_c001;  // x^15+x^14+1

  // Clock cycles per symbol at rate step k: BASE_DIV/k rounded to nearest.
  function automatic int unsigned div_tab(input int unsigned base_div,
                                          input int unsigned k);
    return (base_div + k / 32'd2) / k;
  endfunction

endpackage

// File: rtl/prbs_line_tx_if.sv
// prbs_line_tx_if: control inputs and line/strobe outputs of prbs_line_tx.
// Optional err_inj member exists only when PRBS_LINE_TX_ERR_INJECT_EN is defined.
interface prbs_line_tx_if;
  logic       run;
  logic       rate_up;
  logic       rate_dn;
  logic [1:0] mode;
`ifdef PRBS_LINE_TX_ERR_INJECT_EN
  logic       err_inj;
`endif
  logic [3:0] rate;
  logic       sym_en;
  logic       half_en;
  logic       bit_clk;
  logic       data_bit;
  logic       line_out;

  // Control side: drives run/rate/mode, observes the stream.
  modport master (
`ifdef PRBS_LINE_TX_ERR_INJECT_EN
    output err_inj,
`endif
    output run, rate_up, rate_dn, mode,
    input  rate, sym_en, half_en, bit_clk, data_bit, line_out
  );

  // Transmitter side.
  modport slave (
`ifdef PRBS_LINE_TX_ERR_INJECT_EN
    input  err_inj,
`endif
    input  run, rate_up, rate_dn, mode,
    output rate, sym_en, half_en, bit_clk, data_bit, line_out
  );
endinterface

// File: rtl/prbs_galois.sv
// prbs_galois: W-bit right-shifting Galois LFSR seeded with 1; steps on adv.
// MASK holds the full feedback polynomial including bit W.
module prbs_galois #(
  parameter int          W    = 8,
  parameter logic [32:0] MASK = 33'h0_0000_011d
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  output logic [W-1:0] lfsr
);

  localparam logic [W-1:0] TAPS = MASK[W:1];
  localparam logic [W-1:0] SEED = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_lfsr;

  // Shift state one step per advance, folding the taps back in when bit 0 is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else if (adv) begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : {W{1'b0}});
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

  assign lfsr = r_lfsr;

endmodule

// File: rtl/prbs_line_tx.sv
// prbs_line_tx: PRBS test transmitter with selectable bit rate and line code
// (NRZ, Manchester, differential Manchester, NRZI).
// Optional build macro PRBS_LINE_TX_ERR_INJECT_EN adds single-bit error injection.
module prbs_line_tx
  import prbs_line_pkg::*;
#(
  parameter int          W        = 8,
  parameter logic [32:0] MASK     = 33'h0_0000_011d,
  parameter int          BASE_DIV = 10000,
  parameter int          RATE_MAX = 10,
  parameter int          DIV_W    = 14
) (
  input  logic          clk,
  input  logic          rst,
  prbs_line_tx_if.slave bus
);

  localparam logic [3:0]       RATE_TOP = 4'(RATE_MAX);
  localparam logic [DIV_W-1:0] ONE      = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]     TAP0     = {{(W-1){1'b0}}, 1'b1};

  // Divider table, indexed by rate; entries outside 1..RATE_MAX are unreachable.
  logic [DIV_W-1:0] w_div_tab [16];
  for (genvar k = 0; k < 16; k++) begin : g_tab
    if (k >= 1 && k <= RATE_MAX) begin : g_used
      localparam logic [DIV_W-1:0] DIV_K = DIV_W'(div_tab(BASE_DIV, k));
      assign w_div_tab[k] = DIV_K;
    end else begin : g_unused
      localparam logic [DIV_W-1:0] DIV_K = DIV_W'(BASE_DIV);
      assign w_div_tab[k] = DIV_K;
    end
  end

  logic [3:0]       r_rate;
  logic [DIV_W-1:0] r_div_act;
  logic [DIV_W-1:0] r_cnt;
  logic             r_bit_clk;
  logic             r_data_bit;
  logic             r_line;
  logic [1:0]       r_mode_act;

  logic             w_sym_en;
  logic             w_half_en;
  logic [W-1:0]     w_lfsr;
  logic             w_prbs_bit;
  logic             w_d;

  assign w_sym_en  = bus.run & (r_cnt == (r_div_act - ONE));
  assign w_half_en = bus.run & (r_cnt == ((r_div_act >> 1) - ONE));

  prbs_galois #(.W(W), .MASK(MASK)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .adv  (w_sym_en),
    .lfsr (w_lfsr)
  );

  // Output tap of the generator is bit 0.
  assign w_prbs_bit = |(w_lfsr & TAP0);

`ifdef PRBS_LINE_TX_ERR_INJECT_EN
  logic r_err_armed;

  // Arm on a pulse, consume on the next symbol; pulses while armed are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_armed <= 1'b0;
    end else if (w_sym_en && r_err_armed) begin
      r_err_armed <= 1'b0;
    end else if (bus.err_inj) begin
      r_err_armed <= 1'b1;
    end else begin
      r_err_armed <= r_err_armed;
    end
  end

  assign w_d = w_prbs_bit ^ r_err_armed;
`else
  assign w_d = w_prbs_bit;
`endif

  // Rate step: up/down with wrap-around, simultaneous pulses cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rate <= 4'd1;
    end else if (bus.rate_up && !bus.rate_dn) begin
      r_rate <= (r_rate == RATE_TOP) ? 4'd1 : r_rate + 4'd1;
    end else if (bus.rate_dn && !bus.rate_up) begin
      r_rate <= (r_rate == 4'd1) ? RATE_TOP : r_rate - 4'd1;
    end else begin
      r_rate <= r_rate;
    end
  end

  // Symbol divider; the active divisor only reloads at a symbol boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= {DIV_W{1'b0}};
      r_div_act <= w_div_tab[1];
    end else if (!bus.run) begin
      r_cnt     <= {DIV_W{1'b0}};
      r_div_act <= r_div_act;
    end else if (w_sym_en) begin
      r_cnt     <= {DIV_W{1'b0}};
      r_div_act <= w_div_tab[r_rate];
    end else begin
      r_cnt     <= r_cnt + ONE;
      r_div_act <= r_div_act;
    end
  end

  // Bit clock: high for the first half of each symbol, low for the second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_clk <= 1'b0;
    end else if (w_sym_en) begin
      r_bit_clk <= 1'b1;
    end else if (w_half_en) begin
      r_bit_clk <= 1'b0;
    end else begin
      r_bit_clk <= r_bit_clk;
    end
  end

  // Line coder: boundary action uses the freshly sampled mode, mid-symbol uses the latched one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line     <= 1'b0;
      r_data_bit <= 1'b0;
      r_mode_act <= MODE_NRZ;
    end else if (w_sym_en) begin
      r_data_bit <= w_d;
      r_mode_act <= bus.mode;
      case (bus.mode)
        MODE_NRZ:  r_line <= w_d;
        MODE_MAN:  r_line <= w_d;
        MODE_DMAN: r_line <= w_d ? r_line : ~r_line;
        MODE_NRZI: r_line <= w_d ? ~r_line : r_line;
        default:   r_line <= r_line;
      endcase
    end else if (w_half_en) begin
      r_data_bit <= r_data_bit;
      r_mode_act <= r_mode_act;
      case (r_mode_act)
        MODE_MAN:  r_line <= ~r_line;
        MODE_DMAN: r_line <= ~r_line;
        default:   r_line <= r_line;
      endcase
    end else begin
      r_line     <= r_line;
      r_data_bit <= r_data_bit;
      r_mode_act <= r_mode_act;
    end
  end

  assign bus.rate     = r_rate;
  assign bus.sym_en   = w_sym_en;
  assign bus.half_en  = w_half_en;
  assign bus.bit_clk  = r_bit_clk;
  assign bus.data_bit = r_data_bit;
  assign bus.line_out = r_line;

endmodule

// File: tb/tb_prbs_line_tx.sv
// tb_prbs_line_tx: scenario bench for prbs_line_tx with a symbol-level model
// (GF(2) polynomial state, per-symbol waveform expectations per line code).
module tb_prbs_line_tx;
  import prbs_line_pkg::*;

  localparam int          W        = 8;
  localparam logic [32:0] MASK     = 33'h0_0000_011d;
  localparam int          BASE_DIV = 40;
  localparam int          RATE_MAX = 10;
  localparam int          DIV_W    = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;

  prbs_line_tx_if bus();

  prbs_line_tx #(.W(W), .MASK(MASK), .BASE_DIV(BASE_DIV), .RATE_MAX(RATE_MAX), .DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state
  int unsigned m_state;
  bit          m_line;
  bit          m_last_d;
  int          m_rate;
  int          m_div;
  int          m_rem;
  logic [1:0]  m_mode_act;
  bit          m_inj;
  logic [1:0]  g_mode;
  bit          obs_bits[$];

  function automatic int tab(input int k);
    return (BASE_DIV + k / 2) / k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sym(input int budget, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      tick();
      n++;
      if (bus.sym_en === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    bus.run = 1'b0; bus.rate_up = 1'b0; bus.rate_dn = 1'b0; bus.mode = MODE_NRZ;
`ifdef PRBS_LINE_TX_ERR_INJECT_EN
    bus.err_inj = 1'b0;
`endif
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    m_state = 1; m_line = 1'b0; m_last_d = 1'b0; m_rate = 1; m_div = tab(1);
    m_mode_act = MODE_NRZ; m_inj = 1'b0; g_mode = MODE_NRZ;
  endtask

  task automatic pulse(input bit up, input bit dn);
    bus.rate_up = up; bus.rate_dn = dn;
    tick();
    bus.rate_up = 1'b0; bus.rate_dn = 1'b0;
    tick();
    if (up && !dn) m_rate = (m_rate % RATE_MAX) + 1;
    if (dn && !up) m_rate = ((m_rate - 2 + RATE_MAX) % RATE_MAX) + 1;
  endtask

  // Run n symbols in mode md; switch the mode input to nxt mid-way through the last one.
  task automatic run_symbols(input int n, input logic [1:0] md, input logic [1:0] nxt);
    int cnt; bit ok; bit d; bit first; bit second;
    for (int i = 0; i < n; i++) begin
      wait_sym(m_rem + 8, cnt, ok);
      checks++;
      if (!ok || cnt != m_rem) begin
        errors++;
        $display("FAIL sym_spacing: %0d cycles (strobe seen=%0d), expected %0d", cnt, ok, m_rem);
      end
      d = m_state[0] ^ m_inj;
      m_inj = 1'b0;
      // multiply by x^-1 modulo the feedback polynomial
      if (m_state[0]) m_state = (m_state ^ MASK[31:0]) >> 1;
      else            m_state = m_state >> 1;
      m_div = tab(m_rate);
      m_mode_act = md;
      case (md)
        MODE_NRZ:  begin first = d;                    second = d;      end
        MODE_MAN:  begin first = d;                    second = !d;     end
        MODE_DMAN: begin first = d ? m_line : !m_line; second = !first; end
        default:   begin first = d ? !m_line : m_line; second = first;  end
      endcase
      tick();
      checks++;
      if ({bus.data_bit, bus.line_out, bus.bit_clk} !== {d, first, 1'b1}) begin
        errors++;
        $display("FAIL first_half mode=%0d: data,line,bclk=%b%b%b expected %b%b%b",
                 md, bus.data_bit, bus.line_out, bus.bit_clk, d, first, 1'b1);
      end
      obs_bits.push_back(bus.data_bit);
      if (i == n - 1) bus.mode = nxt;
      repeat (m_div / 2) tick();
      checks++;
      if ({bus.line_out, bus.bit_clk} !== {second, 1'b0}) begin
        errors++;
        $display("FAIL second_half mode=%0d: line,bclk=%b%b expected %b%b",
                 md, bus.line_out, bus.bit_clk, second, 1'b0);
      end
      m_line = second;
      m_last_d = d;
      m_rem = m_div - 1 - m_div / 2;
    end
    g_mode = nxt;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.rate !== 4'd1) begin
      errors++; $display("FAIL reset_rate: got %0d expected 1", bus.rate);
    end
    checks++;
    if ({bus.sym_en, bus.half_en, bus.bit_clk, bus.data_bit, bus.line_out} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs: sym,half,bclk,data,line=%b%b%b%b%b expected 00000",
               bus.sym_en, bus.half_en, bus.bit_clk, bus.data_bit, bus.line_out);
    end
  endtask

  task automatic test_rate();
    int n; bit ok; int highs; int halves;
    do_reset();
    bus.run = 1'b1;
    wait_sym(100, n, ok);
    checks++;
    if (!ok || n != tab(1) - 1) begin
      errors++; $display("FAIL first_symbol: %0d cycles (seen=%0d) expected %0d", n, ok, tab(1) - 1);
    end
    highs = 0; halves = 0;
    for (int i = 0; i < tab(1); i++) begin
      tick();
      if (bus.bit_clk === 1'b1) highs++;
      if (bus.half_en === 1'b1) halves++;
    end
    checks++;
    if (highs != tab(1) / 2 || halves != 1 || bus.sym_en !== 1'b1) begin
      errors++;
      $display("FAIL bit_clk_duty: high=%0d halves=%0d sym=%b expected %0d 1 1", highs, halves, bus.sym_en, tab(1) / 2);
    end
    // nine up pulses starting on a symbol boundary (2 cycles each)
    for (int i = 0; i < 9; i++) pulse(1'b1, 1'b0);
    checks++;
    if (bus.rate !== 4'(m_rate) || m_rate != 10) begin
      errors++; $display("FAIL rate_up9: got %0d expected %0d", bus.rate, m_rate);
    end
    wait_sym(100, n, ok);
    checks++;
    if (!ok || n != tab(1) - 18) begin
      errors++; $display("FAIL old_period_kept: %0d cycles expected %0d", n, tab(1) - 18);
    end
    wait_sym(100, n, ok);
    checks++;
    if (!ok || n != tab(10)) begin
      errors++; $display("FAIL period_rate10: %0d cycles expected %0d", n, tab(10));
    end
    pulse(1'b1, 1'b0);
    checks++;
    if (bus.rate !== 4'd1) begin
      errors++; $display("FAIL rate_wrap_up: got %0d expected 1", bus.rate);
    end
    wait_sym(100, n, ok);
    checks++;
    if (!ok || n != tab(10) - 2) begin
      errors++; $display("FAIL wrap_symbol_complete: %0d cycles expected %0d", n, tab(10) - 2);
    end
    wait_sym(100, n, ok);
    checks++;
    if (!ok || n != tab(1)) begin
      errors++; $display("FAIL period_back_to_1: %0d cycles expected %0d", n, tab(1));
    end
    pulse(1'b1, 1'b1);
    checks++;
    if (bus.rate !== 4'd1) begin
      errors++; $display("FAIL rate_both: got %0d expected 1", bus.rate);
    end
    pulse(1'b0, 1'b1);
    checks++;
    if (bus.rate !== 4'(RATE_MAX)) begin
      errors++; $display("FAIL rate_wrap_dn: got %0d expected %0d", bus.rate, RATE_MAX);
    end
    pulse(1'b0, 1'b1);
    checks++;
    if (bus.rate !== 4'(RATE_MAX - 1)) begin
      errors++; $display("FAIL rate_dn: got %0d expected %0d", bus.rate, RATE_MAX - 1);
    end
  endtask

  task automatic test_nrz_prbs();
    int ones;
    do_reset();
    pulse(1'b0, 1'b1);
    bus.mode = MODE_NRZ;
    bus.run = 1'b1;
    m_rem = m_div - 1;
    obs_bits.delete();
    run_symbols(259, MODE_NRZ, MODE_NRZ);
    ones = 0;
    for (int i = 0; i < 255; i++) if (obs_bits[i]) ones++;
    checks++;
    if (ones != 128) begin
      errors++; $display("FAIL prbs_ones: got %0d expected 128", ones);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_bits[i + 255] !== obs_bits[i]) begin
        errors++; $display("FAIL prbs_repeat[%0d]: got %b expected %b", i, obs_bits[i + 255], obs_bits[i]);
      end
    end
  endtask

  task automatic test_line_codes();
    logic [1:0] seq [6];
    seq[0] = MODE_MAN; seq[1] = MODE_DMAN; seq[2] = MODE_NRZI;
    seq[3] = 2'($urandom_range(0, 3)); seq[4] = MODE_DMAN; seq[5] = 2'($urandom_range(0, 3));
    for (int s = 0; s < 6; s++) begin
      run_symbols(int'($urandom_range(3, 8)), g_mode, seq[s]);
    end
    run_symbols(4, g_mode, g_mode);
  endtask

  task automatic test_run_hold();
    int hold;
    for (int r = 0; r < 2; r++) begin
      bus.run = 1'b0;
      hold = int'($urandom_range(5, 20));
      for (int i = 0; i < hold; i++) begin
        tick();
        checks++;
        if ({bus.sym_en, bus.half_en, bus.bit_clk, bus.data_bit, bus.line_out, bus.rate}
            !== {1'b0, 1'b0, 1'b0, m_last_d, m_line, 4'(m_rate)}) begin
          errors++;
          $display("FAIL run_hold: sym,half,bclk,data,line=%b%b%b%b%b rate=%0d expected 00%b%b%b rate=%0d",
                   bus.sym_en, bus.half_en, bus.bit_clk, bus.data_bit, bus.line_out, bus.rate,
                   1'b0, m_last_d, m_line, m_rate);
        end
      end
      bus.run = 1'b1;
      m_rem = m_div - 1;
      // the restarted symbol passes its midpoint again before the next boundary
      if (m_mode_act == MODE_MAN || m_mode_act == MODE_DMAN) m_line = !m_line;
      run_symbols(int'($urandom_range(2, 5)), g_mode, (r == 0) ? MODE_MAN : g_mode);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.rate, bus.bit_clk, bus.data_bit, bus.line_out} !== {4'd1, 3'b000}) begin
      errors++;
      $display("FAIL async_reset: rate=%0d bclk,data,line=%b%b%b expected rate=1 000",
               bus.rate, bus.bit_clk, bus.data_bit, bus.line_out);
    end
    #1 rst = 1'b0;
    m_state = 1; m_line = 1'b0; m_rate = 1; m_div = tab(1); m_mode_act = MODE_NRZ;
    m_rem = m_div - 1;
    run_symbols(6, g_mode, g_mode);
  endtask

`ifdef PRBS_LINE_TX_ERR_INJECT_EN
  task automatic test_err_inject();
    bus.err_inj = 1'b1; tick();
    bus.err_inj = 1'b0; tick();
    bus.err_inj = 1'b1; tick();
    bus.err_inj = 1'b0;
    m_rem = m_rem - 3;
    m_inj = 1'b1;
    run_symbols(5, g_mode, g_mode);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rate();
    test_nrz_prbs();
    test_line_codes();
    test_run_hold();
    test_async_reset();
`ifdef PRBS_LINE_TX_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prbs_line_tx.md
Name: prbs_line_tx

Overview:
- Parametrised successor of the fixed-rate PRBS/Manchester test transmitter.
- Generates a pseudo-random bit stream with a W-bit Galois LFSR and a selectable polynomial.
- Bit rate is selectable from a table of RATE_MAX steps derived from one base divider; the stream is line-coded in one of four modes (NRZ, Manchester, differential Manchester, NRZI).
- Sits between the key/rate control logic and the channel/noise model; provides the bit clock and symbol strobes to the receiver-side sync logic.

Parameters:
- W, 8, LFSR width (3..32)
- MASK, 32'h11d, feedback polynomial including bit W; must be primitive
- BASE_DIV, 10000, clk cycles per symbol at rate index 1
- RATE_MAX, 10, number of rate steps (2..15)
- DIV_W, 14, divider counter width; must satisfy BASE_DIV <= 2^DIV_W-1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- run  in  1  1 = transmit, 0 = idle/hold
- rate_up  in  1  single-cycle pulse, next rate step
- rate_dn  in  1  single-cycle pulse, previous rate step
- mode  in  2  line code: 0 NRZ, 1 Manchester, 2 diff-Manchester, 3 NRZI
- rate  out  4  current rate index, 1..RATE_MAX
- sym_en  out  1  one-cycle strobe at end of each symbol
- half_en  out  1  one-cycle strobe at mid-symbol
- bit_clk  out  1  registered bit clock, 50% nominal duty
- data_bit  out  1  current uncoded PRBS bit
- line_out  out  1  registered line-coded output

Behaviour:
- Reset values: rate=1, div_act=DIV_TAB[1], cnt=0, lfsr=1, data_bit=0, bit_clk=0, line_out=0, level=0, mode_act=0, sym_en=0, half_en=0.
- DIV_TAB[k] = (BASE_DIV + k/2)/k, computed at elaboration by a constant function, integer rounding. Defaults give 10000, 5000, 3333, 2500, 2000, 1667, 1429, 1250, 1111, 1000.
- Rate select:
  - rate_up alone: rate+1; RATE_MAX wraps to 1.
  - rate_dn alone: rate-1; 1 wraps to RATE_MAX.
  - Both in the same cycle: no change.
  - rate updates on the cycle after the pulse. div_act reloads from DIV_TAB[rate] only on sym_en, so no symbol is ever truncated.
- Divider:
  - cnt counts 0..div_act-1, then wraps to 0.
  - sym_en is combinational (cnt==div_act-1) and gated by run.
  - half_en is (cnt==(div_act>>1)-1) and gated by run.
- bit_clk: on sym_en goes to 1 next cycle; on half_en goes to 0 next cycle; otherwise holds.
- LFSR: advances on sym_en.
  - data_bit <= lfsr[0].
  - lfsr <= (lfsr>>1) ^ (lfsr[0] ? MASK[W:1] : 0).
  - Period is 2^W-1 symbols; the all-zero state is unreachable.
- mode_act samples mode on sym_en; mid-symbol mode changes never take effect.
- Line coder (registered; d = new data_bit):
  - NRZ: line_out <= d on sym_en.
  - Manchester: on sym_en line_out <= d; on half_en line_out <= ~line_out. So 1 = high-then-low, 0 = low-then-high.
  - Diff-Manchester: on sym_en line_out <= d ? line_out : ~line_out; on half_en line_out <= ~line_out.
  - NRZI: on sym_en, if d then line_out <= ~line_out.
- run=0: cnt held at 0, no strobes, lfsr/data_bit/line_out/bit_clk hold their values. On run rising, the first sym_en occurs div_act cycles later.
- Reset asserted mid-symbol: every register returns immediately to its reset value, and the stream restarts from seed 1.

Optional Feature:
- Macro: PRBS_LINE_TX_ERR_INJECT_EN.
- Defined: adds input err_inj (1 bit, pulse). A pulse arms a flag; the next data_bit is inverted before coding and the flag then clears. LFSR state is unaffected. Additional pulses while armed are ignored.
- Undefined: port absent, no inversion logic.

Decomposition:
- Package prbs_line_pkg: mode encoding constants (MODE_NRZ=0, MODE_MAN=1, MODE_DMAN=2, MODE_NRZI=3), default MASK constants for W=7/8/12/15, and the div_tab constant function.
- One sub-module prbs_galois (W, MASK; ports clk, rst, adv, lfsr), reusable by the noise generator.
- Divider and coder stay inline.

Test Plan:
- Reset, then run=1 with default parameters -> sym_en every 10000 cycles; bit_clk high 5000, low 5000; rate=1.
- Nine rate_up pulses, then one more -> sym_en period 1000; the tenth pulse gives rate=1 and period 10000 starting at the next symbol boundary. rate_up with rate_dn together -> rate unchanged.
- Rate change requested mid-symbol -> current symbol completes at the old period (no short symbol).
- NRZ over 255 symbols -> data_bit sequence repeats at exactly symbol 256; 128 ones, 127 zeros; first bits match the reference model from seed 1.
- mode=1, data_bit=1 -> line_out high for the first half, low for the second. mode=2 bit pattern 1,0 -> no transition at boundary for 1, transition for 0, transition at every mid-symbol.
- run=0 mid-stream -> no strobes and all outputs frozen. Async rst pulse between clock edges -> outputs return to reset values without waiting for a clock edge. With PRBS_LINE_TX_ERR_INJECT_EN defined, one err_inj pulse -> exactly one inverted bit versus the model.
